// File: rtl/load_arb_pkg.sv
// Shared types and constants for the load/debug port arbiter.
// Used by load_arb_id_fifo and load_port_arbiter.
package load_arb_pkg;

   localparam int   NUM_PORTS = 2;
   localparam logic PORT_SPI  = 1'b0;
   localparam logic PORT_DBG  = 1'b1;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      DRAIN = 2'd1,
      RUN   = 2'd2
   } fetch_state_e;

   // Two-port round robin: the port at the pointer wins if it requests, else the other one.
   function automatic logic rr_pick(input logic [NUM_PORTS-1:0] req, input logic ptr);
      if (req[ptr]) return ptr;
      return ~ptr;
   endfunction

endpackage

// File: rtl/load_arb_id_fifo.sv
// In-order FIFO of 1-bit requester IDs, one entry per outstanding memory transaction.
// Supports push and pop in the same cycle; pops while empty are dropped.
module load_arb_id_fifo #(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             push_id_i,
   input  logic             pop_i,
   output logic             pop_id_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic             id_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   assign full_o   = (count_q == CNT_W'(DEPTH));
   assign empty_o  = (count_q == '0);
   assign count_o  = count_q;
   assign pop_id_o = id_mem[rd_ptr_q];

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign do_push = push_i & (~full_o | pop_i);
   assign do_pop  = pop_i & ~empty_o;

   // NOTE: storage is deliberately not reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) id_mem[wr_ptr_q] <= push_id_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/load_port_arbiter.sv
// Round-robin sharing of the memory load port between the SPI loader and the JTAG bridge,
// response routing by ID FIFO, and core fetch-enable sequencing. Option: LOAD_ARB_SPI_LOCK_EN.
module load_port_arbiter
   import load_arb_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_OUTST = 4,
   localparam int BE_W     = DATA_W / 8
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_PORTS-1:0]              req_i,
   input  logic [NUM_PORTS-1:0]              we_i,
   input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  addr_i,
   input  logic [NUM_PORTS-1:0][DATA_W-1:0]  wdata_i,
   input  logic [NUM_PORTS-1:0][BE_W-1:0]    be_i,
   output logic [NUM_PORTS-1:0]              gnt_o,
   output logic [NUM_PORTS-1:0]              rvalid_o,
   output logic [DATA_W-1:0]                 rdata_o,
   output logic                              mem_req_o,
   output logic                              mem_we_o,
   output logic [ADDR_W-1:0]                 mem_addr_o,
   output logic [DATA_W-1:0]                 mem_wdata_o,
   output logic [BE_W-1:0]                   mem_be_o,
   input  logic                              mem_gnt_i,
   input  logic                              mem_rvalid_i,
   input  logic [DATA_W-1:0]                 mem_rdata_i,
   input  logic                              fetch_req_i,
   output logic                              fetch_enable_o
);

   localparam int CNT_W = $clog2(MAX_OUTST) + 1;

   fetch_state_e      state_q;
   logic              rr_ptr_q;
   logic              hold_q;
   logic              hold_id_q;
   logic [NUM_PORTS-1:0] req_masked;
   logic              winner_valid;
   logic              winner_id;
   logic              handshake;
   logic              pop_valid;
   logic              pop_id;
   logic [CNT_W-1:0]  outst_cnt;
   logic              fifo_full;
   logic              fifo_empty;

   // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      req_masked = req_i;
`ifdef LOAD_ARB_SPI_LOCK_EN
      // Code memory is frozen from the SPI side once the core is running.
      if (state_q == RUN) req_masked[PORT_SPI] = 1'b0;
`endif
   end

   // A stalled request keeps its winner so the presented fields cannot switch under the memory.
   assign winner_valid = hold_q | (|req_masked);
   assign winner_id    = hold_q ? hold_id_q : rr_pick(req_masked, rr_ptr_q);
   assign mem_req_o    = winner_valid & ~fifo_full;
   assign handshake    = mem_req_o & mem_gnt_i;
   assign pop_valid    = mem_rvalid_i & ~fifo_empty;
   assign rdata_o      = mem_rdata_i;

   always_comb begin
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
      gnt_o       = '0;
      if (mem_req_o) begin
         mem_we_o    = we_i[winner_id];
         mem_addr_o  = addr_i[winner_id];
         mem_wdata_o = wdata_i[winner_id];
         mem_be_o    = be_i[winner_id];
      end
      if (handshake) gnt_o[winner_id] = 1'b1;
   end

   always_comb begin
      rvalid_o           = '0;
      rvalid_o[PORT_SPI] = pop_valid & (pop_id == PORT_SPI);
      rvalid_o[PORT_DBG] = pop_valid & (pop_id == PORT_DBG);
   end

   load_arb_id_fifo #(
      .DEPTH (MAX_OUTST)
   ) u_id_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_i    (handshake),
      .push_id_i (winner_id),
      .pop_i     (mem_rvalid_i),
      .pop_id_o  (pop_id),
      .count_o   (outst_cnt),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q  <= PORT_SPI;
         hold_q    <= 1'b0;
         hold_id_q <= PORT_SPI;
      end else begin
         if (handshake) rr_ptr_q <= ~winner_id;
         hold_q    <= mem_req_o & ~mem_gnt_i;
         hold_id_q <= winner_id;
      end
   end

   // Fetch enable is registered from the state, so it trails RUN entry and exit by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= LOAD;
         fetch_enable_o <= 1'b0;
      end else begin
         fetch_enable_o <= (state_q == RUN);
         case (state_q)
            LOAD:    if (fetch_req_i) state_q <= DRAIN;
            DRAIN:   if ((outst_cnt == '0) && !mem_req_o) state_q <= RUN;
            RUN:     if (!fetch_req_i) state_q <= LOAD;
            default: state_q <= LOAD;
         endcase
      end
   end

`ifndef SYNTHESIS
   stray_rvalid_a: assert property (@(posedge clk) disable iff (!rst_n)
                                    !(mem_rvalid_i && fifo_empty))
      else $warning("load_port_arbiter: response with nothing outstanding was dropped");
`endif

endmodule

// File: tb/tb_load_port_arbiter.sv
// Directed self-checking bench for load_port_arbiter (inputs driven on negedge, checked #1 later).
module tb_load_port_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BE_W   = DATA_W / 8;

   localparam logic [ADDR_W-1:0] ADDR0 = 32'h0000_1000;
   localparam logic [ADDR_W-1:0] ADDR1 = 32'h0000_2000;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [1:0]             req_i;
   logic [1:0]             we_i;
   logic [1:0][ADDR_W-1:0] addr_i;
   logic [1:0][DATA_W-1:0] wdata_i;
   logic [1:0][BE_W-1:0]   be_i;
   logic [1:0]             gnt_o;
   logic [1:0]             rvalid_o;
   logic [DATA_W-1:0]      rdata_o;
   logic                   mem_req_o;
   logic                   mem_we_o;
   logic [ADDR_W-1:0]      mem_addr_o;
   logic [DATA_W-1:0]      mem_wdata_o;
   logic [BE_W-1:0]        mem_be_o;
   logic                   mem_gnt_i;
   logic                   mem_rvalid_i;
   logic [DATA_W-1:0]      mem_rdata_i;
   logic                   fetch_req_i;
   logic                   fetch_enable_o;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   load_port_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .MAX_OUTST (4)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_i          (req_i),
      .we_i           (we_i),
      .addr_i         (addr_i),
      .wdata_i        (wdata_i),
      .be_i           (be_i),
      .gnt_o          (gnt_o),
      .rvalid_o       (rvalid_o),
      .rdata_o        (rdata_o),
      .mem_req_o      (mem_req_o),
      .mem_we_o       (mem_we_o),
      .mem_addr_o     (mem_addr_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_be_o       (mem_be_o),
      .mem_gnt_i      (mem_gnt_i),
      .mem_rvalid_i   (mem_rvalid_i),
      .mem_rdata_i    (mem_rdata_i),
      .fetch_req_i    (fetch_req_i),
      .fetch_enable_o (fetch_enable_o)
   );

   task automatic idle_inputs();
      req_i        = 2'b00;
      we_i         = 2'b00;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      fetch_req_i = 1'b0;
      idle_inputs();
      addr_i[0]  = ADDR0;
      addr_i[1]  = ADDR1;
      wdata_i[0] = 32'h1111_1111;
      wdata_i[1] = 32'h2222_2222;
      be_i[0]    = 4'hF;
      be_i[1]    = 4'h3;
      @(negedge clk); #1;
      tests++; if (gnt_o !== 2'b00) begin fails++; $display("FAIL reset_gnt: got %b want 00", gnt_o); end
      tests++; if (rvalid_o !== 2'b00) begin fails++; $display("FAIL reset_rvalid: got %b want 00", rvalid_o); end
      tests++; if (mem_req_o !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %b want 0", mem_req_o); end
      tests++; if ({mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o} !== '0) begin
         fails++; $display("FAIL reset_mem_fields: we %b addr %h wdata %h be %h want all 0", mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o);
      end
      tests++; if (fetch_enable_o !== 1'b0) begin fails++; $display("FAIL reset_fetch_en: got %b want 0", fetch_enable_o); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Both ports request for 8 cycles; responses come back one cycle after each grant.
   task automatic test_round_robin();
      logic [1:0] exp_gnt;
      logic [1:0] prev_gnt;
      int n0;
      int n1;
      prev_gnt = 2'b00;
      n0 = 0;
      n1 = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         req_i        = (i < 8) ? 2'b11 : 2'b00;
         we_i         = 2'b01;
         mem_gnt_i    = (i < 8);
         mem_rvalid_i = (i > 0);
         mem_rdata_i  = 32'hA000_0000 + 32'(i);
         #1;
         exp_gnt = (i >= 8) ? 2'b00 : ((i % 2 == 0) ? 2'b01 : 2'b10);
         tests++; if (gnt_o !== exp_gnt) begin fails++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt_o, exp_gnt); end
         if (i < 8) begin
            tests++;
            if (mem_addr_o !== ((i % 2 == 0) ? ADDR0 : ADDR1) || mem_we_o !== (i % 2 == 0)) begin
               fails++; $display("FAIL rr_fields[%0d]: addr %h we %b", i, mem_addr_o, mem_we_o);
            end
         end
         tests++; if (rvalid_o !== prev_gnt) begin fails++; $display("FAIL rr_rvalid[%0d]: got %b want %b", i, rvalid_o, prev_gnt); end
         tests++; if (rdata_o !== 32'hA000_0000 + 32'(i)) begin fails++; $display("FAIL rr_rdata[%0d]: got %h", i, rdata_o); end
         if (gnt_o[0]) n0++;
         if (gnt_o[1]) n1++;
         prev_gnt = exp_gnt;
      end
      tests++; if (n0 != 4 || n1 != 4) begin fails++; $display("FAIL rr_counts: port0 %0d port1 %0d want 4 each", n0, n1); end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_stall();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         req_i     = 2'b10;
         mem_gnt_i = 1'b0;
         #1;
         tests++;
         if (mem_req_o !== 1'b1 || mem_addr_o !== ADDR1 || gnt_o !== 2'b00) begin
            fails++; $display("FAIL stall[%0d]: req %b addr %h gnt %b want 1 %h 00", i, mem_req_o, mem_addr_o, gnt_o, ADDR1);
         end
      end
      @(negedge clk);
      mem_gnt_i = 1'b1;
      #1;
      tests++; if (gnt_o !== 2'b10) begin fails++; $display("FAIL stall_release: got %b want 10", gnt_o); end
      @(negedge clk);
      req_i        = 2'b00;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b1;
      #1;
      tests++; if (gnt_o !== 2'b00) begin fails++; $display("FAIL stall_single_pulse: got %b want 00", gnt_o); end
      tests++; if (rvalid_o !== 2'b10) begin fails++; $display("FAIL stall_rvalid: got %b want 10", rvalid_o); end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         req_i        = (i < 3) ? 2'b10 : 2'b00;
         mem_gnt_i    = (i < 3);
         mem_rvalid_i = (i > 0);
         #1;
         tests++; if (gnt_o !== ((i < 3) ? 2'b10 : 2'b00)) begin fails++; $display("FAIL b2b_gnt[%0d]: got %b", i, gnt_o); end
         tests++; if (rvalid_o !== ((i > 0) ? 2'b10 : 2'b00)) begin fails++; $display("FAIL b2b_rvalid[%0d]: got %b", i, rvalid_o); end
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_full();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         req_i     = 2'b01;
         mem_gnt_i = 1'b1;
         #1;
         tests++;
         if (i < 4 && (mem_req_o !== 1'b1 || gnt_o !== 2'b01)) begin
            fails++; $display("FAIL full_fill[%0d]: req %b gnt %b want 1 01", i, mem_req_o, gnt_o);
         end else if (i == 4 && (mem_req_o !== 1'b0 || gnt_o !== 2'b00)) begin
            fails++; $display("FAIL full_block: req %b gnt %b want 0 00", mem_req_o, gnt_o);
         end
      end
      @(negedge clk);
      mem_rvalid_i = 1'b1;
      #1;
      tests++; if (rvalid_o !== 2'b01 || mem_req_o !== 1'b0) begin
         fails++; $display("FAIL full_pop: rvalid %b req %b want 01 0", rvalid_o, mem_req_o);
      end
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      #1;
      tests++; if (mem_req_o !== 1'b1 || gnt_o !== 2'b01) begin
         fails++; $display("FAIL full_regrant: req %b gnt %b want 1 01", mem_req_o, gnt_o);
      end
      @(negedge clk);
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         mem_rvalid_i = 1'b1;
         #1;
         tests++; if (rvalid_o !== 2'b01) begin fails++; $display("FAIL full_drain[%0d]: got %b want 01", i, rvalid_o); end
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_fetch();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         req_i     = 2'b10;
         mem_gnt_i = 1'b1;
         #1;
         tests++; if (gnt_o !== 2'b10) begin fails++; $display("FAIL fetch_issue[%0d]: got %b want 10", i, gnt_o); end
      end
      @(negedge clk);
      idle_inputs();
      fetch_req_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         tests++; if (fetch_enable_o !== 1'b0) begin fails++; $display("FAIL fetch_hold[%0d]: got %b want 0", i, fetch_enable_o); end
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         mem_rvalid_i = 1'b1;
         #1;
         tests++; if (rvalid_o !== 2'b10 || fetch_enable_o !== 1'b0) begin
            fails++; $display("FAIL fetch_drain[%0d]: rvalid %b fen %b want 10 0", i, rvalid_o, fetch_enable_o);
         end
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mem_rvalid_i = 1'b0;
         #1;
         tests++; if (fetch_enable_o !== (i == 2)) begin
            fails++; $display("FAIL fetch_rise[%0d]: got %b want %b", i, fetch_enable_o, (i == 2));
         end
      end
   endtask

   // Runs in RUN state; the SPI lock build must only ever grant the debug port.
   task automatic test_spi_lock();
      logic [1:0] exp_gnt;
      logic [1:0] prev_gnt;
      prev_gnt = 2'b00;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         req_i        = (i < 4) ? 2'b11 : 2'b00;
         mem_gnt_i    = (i < 4);
         mem_rvalid_i = (i > 0);
         #1;
`ifdef LOAD_ARB_SPI_LOCK_EN
         exp_gnt = (i < 4) ? 2'b10 : 2'b00;
`else
         exp_gnt = (i >= 4) ? 2'b00 : ((i % 2 == 0) ? 2'b01 : 2'b10);
`endif
         tests++; if (gnt_o !== exp_gnt) begin fails++; $display("FAIL run_gnt[%0d]: got %b want %b", i, gnt_o, exp_gnt); end
         tests++; if (rvalid_o !== prev_gnt) begin fails++; $display("FAIL run_rvalid[%0d]: got %b want %b", i, rvalid_o, prev_gnt); end
         prev_gnt = exp_gnt;
      end
      @(negedge clk);
      idle_inputs();
      fetch_req_i = 1'b0;
      #1;
      tests++; if (fetch_enable_o !== 1'b1) begin fails++; $display("FAIL run_fen_before_drop: got %b want 1", fetch_enable_o); end
      @(negedge clk);
      @(negedge clk); #1;
      tests++; if (fetch_enable_o !== 1'b0) begin fails++; $display("FAIL run_fen_fall: got %b want 0", fetch_enable_o); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         req_i     = 2'b01;
         mem_gnt_i = 1'b1;
      end
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b0;
      #1;
      tests++; if (mem_req_o !== 1'b0 || gnt_o !== 2'b00 || fetch_enable_o !== 1'b0) begin
         fails++; $display("FAIL midreset_clear: req %b gnt %b fen %b", mem_req_o, gnt_o, fetch_enable_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mem_rvalid_i = 1'b1;
         #1;
         tests++; if (rvalid_o !== 2'b00 || fetch_enable_o !== 1'b0) begin
            fails++; $display("FAIL midreset_stray[%0d]: rvalid %b fen %b want 00 0", i, rvalid_o, fetch_enable_o);
         end
      end
      @(negedge clk);
      idle_inputs();
      req_i     = 2'b10;
      mem_gnt_i = 1'b1;
      #1;
      tests++; if (gnt_o !== 2'b10) begin fails++; $display("FAIL midreset_fresh_gnt: got %b want 10", gnt_o); end
      @(negedge clk);
      idle_inputs();
      mem_rvalid_i = 1'b1;
      #1;
      tests++; if (rvalid_o !== 2'b10) begin fails++; $display("FAIL midreset_fresh_rvalid: got %b want 10", rvalid_o); end
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_stall();
      test_back_to_back();
      test_full();
      test_fetch();
      test_spi_lock();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/load_port_arbiter.md
Name: load_port_arbiter

Overview:
- Shares the single memory load/debug port between two masters: the SPI-slave loader (port 0) and the JTAG debug bridge (port 1).
- Tracks outstanding transactions so each read response is routed back to the requester that issued it.
- Sequences core start: `fetch_enable_o` is held low until loading is finished and all transactions have drained.
- Sits between the SPI-slave/debug-unit outputs and the memory interconnect, in front of the core fetch-enable pin.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte enables are DATA_W/8 bits)
- MAX_OUTST, 4, maximum outstanding transactions (power of 2, ≥2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_i  in  2  per-port request (index 0 = SPI, 1 = debug)
- we_i  in  2  per-port write enable
- addr_i  in  2×ADDR_W  per-port address
- wdata_i  in  2×DATA_W  per-port write data
- be_i  in  2×DATA_W/8  per-port byte enables
- gnt_o  out  2  per-port grant
- rvalid_o  out  2  per-port response valid
- rdata_o  out  DATA_W  response data, broadcast to both ports
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_be_o  out  DATA_W/8  memory byte enables
- mem_gnt_i  in  1  memory grant
- mem_rvalid_i  in  1  memory response valid (one per granted request, in order)
- mem_rdata_i  in  DATA_W  memory read data
- fetch_req_i  in  1  external fetch-enable request (pad)
- fetch_enable_o  out  1  gated fetch enable to the core

Behaviour:
- Reset values:
  - gnt_o, rvalid_o = 0
  - mem_req_o = 0
  - mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, rdata_o = 0
  - fetch_enable_o = 0
  - round-robin pointer = port 0
  - outstanding count = 0
  - FSM = LOAD
- Arbitration (combinational):
  - Round-robin among asserted req_i, starting from the priority pointer.
  - The winner's fields drive the mem_* outputs.
  - mem_req_o = winner exists AND outstanding < MAX_OUTST.
  - gnt_o[winner] = mem_gnt_i & mem_req_o; at most one gnt_o bit is high per cycle.
- Pointer update:
  - On each handshake (mem_req_o & mem_gnt_i) the pointer moves to the port after the winner.
  - No handshake → pointer holds.
  - A lone requester is granted back-to-back with no idle cycles.
- Requester contract: once req_i is high, the requester holds it and its fields stable until gnt_o. The arbiter never retracts mem_req_o while mem_gnt_i is low.
- Response routing:
  - Each handshake pushes the winner ID into an in-order ID FIFO (depth MAX_OUTST).
  - Each mem_rvalid_i pops the FIFO and asserts rvalid_o[popped ID] in the same cycle.
  - rdata_o = mem_rdata_i, passed through combinationally.
  - Writes also get a response.
- Simultaneous push and pop: count is unchanged, FIFO stays coherent.
- Full (count = MAX_OUTST): mem_req_o is forced low.
- mem_rvalid_i while empty: ignored and flagged by an assertion (synthesis-off).
- Fetch FSM:
  - LOAD → DRAIN when fetch_req_i = 1.
  - DRAIN → RUN when count = 0 and no mem_req_o this cycle.
  - RUN: fetch_enable_o = 1 (registered, so it rises the cycle after RUN is entered).
  - RUN → LOAD if fetch_req_i drops; fetch_enable_o falls in the next cycle.
  - Arbitration is unaffected by FSM state (debug access during RUN is allowed).
- Reset mid-transaction: everything clears immediately. In-flight responses after reset are discarded, because rvalid is dropped while the FIFO is empty.
- Latency: request-to-grant is 0 cycles when the memory grants combinationally.

Optional Feature:
- Macro: LOAD_ARB_SPI_LOCK_EN.
  - Defined: while FSM = RUN, port 0 (SPI) is masked out of arbitration (gnt_o[0] stays 0), protecting code memory once the core runs. Debug remains serviced.
  - Undefined: both ports are arbitrated in all states.

Decomposition:
- Package `load_arb_pkg`:
  - fetch FSM state enum: LOAD, DRAIN, RUN
  - port ID localparams: PORT_SPI = 0, PORT_DBG = 1
  - NUM_PORTS = 2
- Sub-module `load_arb_id_fifo`: synchronous FIFO of 1-bit IDs with count, full/empty, and simultaneous push/pop support, depth MAX_OUTST.

Test Plan:
- Both req_i high for 8 cycles, mem_gnt_i = 1 → grants alternate 0,1,0,1…; 4 each; each rvalid_o returns to the issuing port in order.
- mem_gnt_i held 0 for 5 cycles with req_i[1] = 1 → mem_req_o stays 1 and mem_addr_o stays stable; gnt_o[1] pulses once when mem_gnt_i rises.
- Issue 4 reads with no mem_rvalid_i (MAX_OUTST = 4) → mem_req_o = 0 on the 5th request; one mem_rvalid_i pops port 0 → the next request is granted.
- fetch_req_i = 1 with 2 outstanding → fetch_enable_o stays 0 until both rvalids are returned, then rises one cycle after DRAIN exits.
- Assert rst_n low with 3 outstanding, then release and send 3 stray mem_rvalid_i → no rvalid_o, fetch_enable_o = 0.
- LOAD_ARB_SPI_LOCK_EN defined, in RUN, req_i = 2'b11 → only gnt_o[1] is ever asserted; undefined → alternation as in the first test.
